// File: rtl/md5_feeder_pkg.sv
// md5_feeder_pkg: state encoding and block-layout constants for md5_feeder.
// MD5_FEEDER_LEN64_EN widens the byte counter to 61 bits (default 29).
package md5_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        PAD,
        LEN,
        START,
        WAIT
    } state_t;

    localparam logic [7:0] PAD_BYTE        = 8'h80;
    localparam int         WORDS_PER_BLOCK = 16;
    localparam logic [3:0] LEN_LO_IDX      = 4'd14;
    localparam logic [3:0] LEN_HI_IDX      = 4'd15;
    localparam logic [3:0] LAST_DATA_IDX   = 4'd13;

`ifdef MD5_FEEDER_LEN64_EN
    localparam int CNT_W = 61;
`else
    localparam int CNT_W = 29;
`endif

    // One 32-bit half of the message bit length (byte count * 8).
    function automatic logic [31:0] len_word(
        input logic [CNT_W-1:0] nbytes,
        input logic             hi
    );
`ifdef MD5_FEEDER_LEN64_EN
        logic [63:0] bits;
        bits = 64'(nbytes) << 3;
        return hi ? bits[63:32] : bits[31:0];
`else
        return hi ? 32'h0 : {nbytes, 3'b000};
`endif
    endfunction

endpackage

// File: rtl/md5_feeder_padword.sv
// md5_feeder_padword: masks the final message word and inserts the 0x80
// pad marker right after the last valid byte (nbytes of 4 passes through).
import md5_feeder_pkg::*;

module md5_feeder_padword (
    input  logic [31:0] in_data,
    input  logic [2:0]  nbytes,
    output logic [31:0] out_data
);

    // keep bytes below nbytes, marker at nbytes, zeros above
    always_comb begin
        out_data = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                out_data[8*b +: 8] = in_data[8*b +: 8];
            end else if (3'(b) == nbytes) begin
                out_data[8*b +: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/md5_feeder.sv
// md5_feeder: streams a message into MD5-padded 512-bit blocks for one of
// two chunk-cruncher units. Optional macro: MD5_FEEDER_LEN64_EN.
import md5_feeder_pkg::*;

module md5_feeder #(
    parameter int UNIT_W = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [UNIT_W-1:0]        msg_unit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic                     in_last,
    input  logic [2:0]               in_nbytes,
    output logic [(1<<UNIT_W)-1:0]   cc_reset,
    output logic [(1<<UNIT_W)-1:0]   cc_start,
    output logic                     cc_write,
    output logic [31:0]              cc_writedata,
    output logic [UNIT_W+3:0]        cc_writeaddr,
    input  logic [(1<<UNIT_W)-1:0]   cc_done,
    output logic                     busy,
    output logic                     msg_done
);

    localparam int         NU       = 1 << UNIT_W;
    localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

    state_t             state, state_nxt;
    logic [UNIT_W-1:0]  unit_q;
    logic [NU-1:0]      unit_oh;
    logic [3:0]         idx_q, idx_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               pend_q, pend_nxt;
    logic               tail_q, tail_nxt;
    logic               fin_q, fin_nxt;
    logic               first_q;
    logic               wr_en;
    logic [31:0]        wr_data;
    logic [31:0]        pad_word;
    logic [2:0]         inc;

    assign unit_oh = NU'(1) << unit_q;

    md5_feeder_padword u_padword (
        .in_data  (in_data),
        .nbytes   (in_nbytes),
        .out_data (pad_word)
    );

    // next state, block bookkeeping and the word written this cycle
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        pend_nxt  = pend_q;
        tail_nxt  = tail_q;
        fin_nxt   = fin_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        inc       = in_last ? in_nbytes : 3'd4;
        unique case (state)
            IDLE: begin
                idx_nxt  = '0;
                cnt_nxt  = '0;
                pend_nxt = 1'b0;
                tail_nxt = 1'b0;
                fin_nxt  = 1'b0;
                if (in_valid) state_nxt = INIT;
            end
            INIT: state_nxt = FILL;
            FILL: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = in_last ? pad_word : in_data;
                    idx_nxt = idx_q + 4'd1;
                    cnt_nxt = cnt_q + CNT_W'(inc);
                    if (in_last) begin
                        tail_nxt = 1'b1;
                        pend_nxt = (in_nbytes == 3'd4);
                        if (idx_q == LAST_IDX) begin
                            state_nxt = START;
                        end else if (idx_q == LAST_DATA_IDX &&
                                     in_nbytes != 3'd4) begin
                            state_nxt = LEN;
                        end else begin
                            state_nxt = PAD;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_nxt = START;
                    end
                end
            end
            PAD: begin
                wr_en    = 1'b1;
                wr_data  = pend_q ? {24'h0, PAD_BYTE} : '0;
                pend_nxt = 1'b0;
                idx_nxt  = idx_q + 4'd1;
                if (idx_q == LAST_DATA_IDX) begin
                    state_nxt = LEN;
                end else if (idx_q == LAST_IDX) begin
                    state_nxt = START;
                end
            end
            LEN: begin
                wr_en   = 1'b1;
                wr_data = len_word(cnt_q, idx_q != LEN_LO_IDX);
                idx_nxt = idx_q + 4'd1;
                if (idx_q == LEN_HI_IDX) begin
                    fin_nxt   = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (!first_q && cc_done[unit_q]) begin
                    if (fin_q) begin
                        state_nxt = IDLE;
                    end else if (tail_q) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, message counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            unit_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            tail_q       <= 1'b0;
            fin_q        <= 1'b0;
            first_q      <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            cc_reset     <= '0;
            cc_start     <= '0;
            cc_write     <= 1'b0;
            cc_writedata <= '0;
            cc_writeaddr <= '0;
            msg_done     <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx_q        <= idx_nxt;
            cnt_q        <= cnt_nxt;
            pend_q       <= pend_nxt;
            tail_q       <= tail_nxt;
            fin_q        <= fin_nxt;
            first_q      <= (state == START);
            if (state == IDLE && in_valid) unit_q <= msg_unit;
            in_ready     <= (state_nxt == FILL);
            busy         <= (state_nxt != IDLE);
            cc_reset     <= (state == INIT) ? unit_oh : '0;
            cc_start     <= (state == START) ? unit_oh : '0;
            cc_write     <= wr_en;
            cc_writedata <= wr_data;
            cc_writeaddr <= {unit_q, idx_q};
            msg_done     <= (state == WAIT) && (state_nxt == IDLE);
        end
    end

endmodule
